// File: rtl/bitonic_pkg.sv
// Shared types and helpers for the bitonic merger pipeline.
// Latency: none (package only).
// Backpressure: none (package only).
package bitonic_pkg;

    // Sort direction travelling with each vector.
    typedef enum logic {
        ASCEND  = 1'b0,
        DESCEND = 1'b1
    } dir_e;

    // Number of compare-and-swap stages for an n-element merge: log2(n).
    function automatic int stage_count(input int n);
        int s;
        s = 0;
        for (int v = 1; v < n; v = v * 2) begin
            s++;
        end
        return s;
    endfunction

endpackage

// File: rtl/bitonic_merge_stage.sv
// One compare-and-swap layer of the bitonic merge plus its pipeline register.
// Latency: 1 cycle (registered output).
// Backpressure: holds data, valid, mode and direction whenever en_i is low.
module bitonic_merge_stage
    import bitonic_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 16,
    parameter int STAGE      = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 valid_i,
    input  logic                 sign_i,
    input  dir_e                 dir_i,
    input  logic [DATAWIDTH-1:0] x_i [DATALENGTH],
    output logic                 valid_o,
    output logic                 sign_o,
    output dir_e                 dir_o,
    output logic [DATAWIDTH-1:0] y_o [DATALENGTH]
);

    // Pair distance for this layer and index width into the vector.
    localparam int D    = DATALENGTH >> (STAGE + 1);
    localparam int LOGD = $clog2(D);
    localparam int IDXW = $clog2(DATALENGTH);

    logic [DATAWIDTH-1:0] nxt [DATALENGTH];
    logic [DATAWIDTH-1:0] ka;
    logic [DATAWIDTH-1:0] kb;
    logic [IDXW-1:0]      lo;
    logic [IDXW-1:0]      hi;
    logic                 swap;
    int                   lo_n;

    // Compare every (lo, lo+D) pair; flipping the MSB turns a signed compare
    // into an unsigned one, so a single magnitude comparator serves both modes.
    always_comb begin
        nxt  = x_i;
        ka   = '0;
        kb   = '0;
        lo   = '0;
        hi   = '0;
        swap = 1'b0;
        lo_n = 0;
        for (int p = 0; p < DATALENGTH / 2; p++) begin
            lo_n = ((p >> LOGD) << (LOGD + 1)) | (p & (D - 1));
            lo   = IDXW'(lo_n);
            hi   = IDXW'(lo_n + D);
            ka   = {x_i[lo][DATAWIDTH-1] ^ sign_i, x_i[lo][DATAWIDTH-2:0]};
            kb   = {x_i[hi][DATAWIDTH-1] ^ sign_i, x_i[hi][DATAWIDTH-2:0]};
            // Strict compares keep equal values in place.
            swap = (dir_i == ASCEND) ? (ka > kb) : (ka < kb);
            if (swap) begin
                nxt[lo] = x_i[hi];
                nxt[hi] = x_i[lo];
            end
        end
    end

    // Stage register: cleared by reset, advances only when the pipe is enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            sign_o  <= 1'b0;
            dir_o   <= ASCEND;
            y_o     <= '{default: '0};
        end else if (en_i) begin
            valid_o <= valid_i;
            sign_o  <= sign_i;
            dir_o   <= dir_i;
            y_o     <= nxt;
        end
    end

endmodule

// File: rtl/bitonic_merger_pipe.sv
// Pipelined bitonic merger: sorts a bitonic vector ascending or descending.
// Latency: log2(DATALENGTH) cycles, one vector per cycle sustained.
// Backpressure: all stages stall together while valid_o && !ready_i.
module bitonic_merger_pipe
    import bitonic_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 sign_ctrl_i,
    input  logic                 dir_i,
    input  logic [DATAWIDTH-1:0] x_i [DATALENGTH],
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DATAWIDTH-1:0] y_o [DATALENGTH]
);

    localparam int S = stage_count(DATALENGTH);

    // Reject unsupported geometries at elaboration time.
    if (DATALENGTH < 2 || (DATALENGTH & (DATALENGTH - 1)) != 0) begin : g_bad_len
        $error("bitonic_merger_pipe: DATALENGTH must be a power of two >= 2");
    end
    if (DATAWIDTH < 2) begin : g_bad_width
        $error("bitonic_merger_pipe: DATAWIDTH must be >= 2");
    end

    // Chain entry 0 is the input port; entry s+1 is the output of stage s.
    logic [DATAWIDTH-1:0] chain_dat [S+1][DATALENGTH];
    logic                 chain_vld [S+1];
    logic                 chain_sgn [S+1];
    dir_e                 chain_dir [S+1];

    assign chain_dat[0] = x_i;
    assign chain_vld[0] = valid_i;
    assign chain_sgn[0] = sign_ctrl_i;
    assign chain_dir[0] = dir_e'(dir_i);

    // The whole pipe moves as one unit, so the output slot decides readiness.
    assign ready_o = !valid_o || ready_i;

    for (genvar s = 0; s < S; s++) begin : g_stage
        bitonic_merge_stage #(
            .DATAWIDTH  (DATAWIDTH),
            .DATALENGTH (DATALENGTH),
            .STAGE      (s)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (ready_o),
            .valid_i (chain_vld[s]),
            .sign_i  (chain_sgn[s]),
            .dir_i   (chain_dir[s]),
            .x_i     (chain_dat[s]),
            .valid_o (chain_vld[s+1]),
            .sign_o  (chain_sgn[s+1]),
            .dir_o   (chain_dir[s+1]),
            .y_o     (chain_dat[s+1])
        );
    end

    assign valid_o = chain_vld[S];
    assign y_o     = chain_dat[S];

endmodule

// File: tb/tb_bitonic_merger_pipe.sv
// Directed bench for bitonic_merger_pipe with 8- and 4-element instances.
// Latency: checks exact log2(N) output timing.
// Backpressure: exercises output stall, reset flush and back-to-back flow.
module tb_bitonic_merger_pipe;

    typedef logic [7:0] arr8_t [8];
    typedef logic [7:0] arr4_t [4];

    typedef struct {
        logic  sign;
        logic  dir;
        arr8_t x;
        arr8_t y;
    } vec8_t;

    logic clk;
    logic rst;

    logic       v8, r8, s8, d8, rdy8, vo8;
    logic [7:0] x8 [8];
    logic [7:0] y8 [8];

    logic       v4, r4, s4, d4, rdy4, vo4;
    logic [7:0] x4 [4];
    logic [7:0] y4 [4];

    int    errors;
    int    checks;
    vec8_t tab [7];

    bitonic_merger_pipe #(.DATAWIDTH(8), .DATALENGTH(8)) dut8 (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (v8),
        .ready_o     (rdy8),
        .sign_ctrl_i (s8),
        .dir_i       (d8),
        .x_i         (x8),
        .valid_o     (vo8),
        .ready_i     (r8),
        .y_o         (y8)
    );

    bitonic_merger_pipe #(.DATAWIDTH(8), .DATALENGTH(4)) dut4 (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (v4),
        .ready_o     (rdy4),
        .sign_ctrl_i (s4),
        .dir_i       (d4),
        .x_i         (x4),
        .valid_o     (vo4),
        .ready_i     (r4),
        .y_o         (y4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pack8(input arr8_t a);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) p[i*8 +: 8] = a[i];
        return p;
    endfunction

    function automatic logic [63:0] pack4(input arr4_t a);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) p[i*8 +: 8] = a[i];
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set8(input int k, input logic s, input logic d, input arr8_t x, input arr8_t y);
        tab[k].sign = s;
        tab[k].dir  = d;
        tab[k].x    = x;
        tab[k].y    = y;
    endtask

    task automatic drive8(input int k);
        s8 = tab[k].sign;
        d8 = tab[k].dir;
        x8 = tab[k].x;
    endtask

    // Single vector through an empty pipe: latency and sorted result.
    task automatic run8(input int k);
        int lat;
        @(negedge clk);
        drive8(k);
        v8 = 1'b1;
        r8 = 1'b1;
        @(negedge clk);
        v8  = 1'b0;
        lat = 1;
        while (!vo8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("lat[%0d]", k), 64'(lat), 64'd3);
        check($sformatf("y[%0d]", k), pack8(y8), pack8(tab[k].y));
    endtask

    initial begin
        int sent, got, stall_cnt, leak;
        logic stall_done;

        errors = 0;
        checks = 0;

        set8(0, 1'b0, 1'b0, '{8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd6, 8'd4, 8'd2},
                            '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
        set8(1, 1'b0, 1'b1, '{8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd6, 8'd4, 8'd2},
                            '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        set8(2, 1'b0, 1'b0, '{8'd2, 8'd2, 8'd5, 8'd5, 8'd4, 8'd4, 8'd1, 8'd1},
                            '{8'd1, 8'd1, 8'd2, 8'd2, 8'd4, 8'd4, 8'd5, 8'd5});
        set8(3, 1'b1, 1'b0, '{8'hF0, 8'h10, 8'h20, 8'h7F, 8'h05, 8'h00, 8'hFF, 8'h80},
                            '{8'h80, 8'hF0, 8'hFF, 8'h00, 8'h05, 8'h10, 8'h20, 8'h7F});
        set8(4, 1'b0, 1'b1, '{8'h00, 8'h40, 8'h80, 8'hFF, 8'hFE, 8'h90, 8'h10, 8'h01},
                            '{8'hFF, 8'hFE, 8'h90, 8'h80, 8'h40, 8'h10, 8'h01, 8'h00});
        set8(5, 1'b1, 1'b1, '{8'hF0, 8'h10, 8'h20, 8'h7F, 8'h05, 8'h00, 8'hFF, 8'h80},
                            '{8'h7F, 8'h20, 8'h10, 8'h05, 8'h00, 8'hFF, 8'hF0, 8'h80});
        set8(6, 1'b1, 1'b0, '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE},
                            '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE});

        // Reset with an input offered: it must be dropped.
        rst = 1'b1;
        v8 = 1'b1; r8 = 1'b1; drive8(0);
        v4 = 1'b1; r4 = 1'b1; s4 = 1'b0; d4 = 1'b0;
        x4 = '{8'd9, 8'd9, 8'd9, 8'd9};
        repeat (2) @(negedge clk);
        check("rst_vo8", 64'(vo8), 64'd0);
        check("rst_rdy8", 64'(rdy8), 64'd1);
        check("rst_y8", pack8(y8), 64'd0);
        check("rst_vo4", 64'(vo4), 64'd0);
        check("rst_y4", pack4(y4), 64'd0);
        rst = 1'b0;
        v8 = 1'b0;
        v4 = 1'b0;
        leak = 0;
        repeat (6) begin
            @(negedge clk);
            if (vo8 || vo4) leak++;
        end
        check("rst_input_ignored", 64'(leak), 64'd0);

        // Table-driven single vectors with gaps (bubbles) between them.
        for (int k = 0; k < 7; k++) run8(k);

        // Mixed sign mode back-to-back on the 4-element instance.
        @(negedge clk);
        x4 = '{8'h01, 8'h7F, 8'hFF, 8'h80};
        s4 = 1'b1; d4 = 1'b0; v4 = 1'b1; r4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        check("n4_lat_early", 64'(vo4), 64'd0);
        @(negedge clk);
        v4 = 1'b0;
        check("n4_vo_a", 64'(vo4), 64'd1);
        check("n4_signed", pack4(y4), pack4('{8'h80, 8'hFF, 8'h01, 8'h7F}));
        @(negedge clk);
        check("n4_vo_b", 64'(vo4), 64'd1);
        check("n4_unsigned", pack4(y4), pack4('{8'h01, 8'h7F, 8'h80, 8'hFF}));
        @(negedge clk);
        check("n4_vo_after", 64'(vo4), 64'd0);

        // Five back-to-back vectors with a 4-cycle output stall.
        sent = 0; got = 0; stall_cnt = 0; stall_done = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            if (vo8 && !stall_done) begin
                stall_done = 1'b1;
                stall_cnt  = 4;
            end
            r8 = (stall_cnt == 0);
            v8 = (sent < 5);
            if (sent < 5) drive8(sent);
            #1;
            if (stall_cnt > 0) begin
                check("stall_rdy", 64'(rdy8), 64'd0);
                stall_cnt--;
            end
            if (vo8) begin
                check($sformatf("stall_y[%0d]", got), pack8(y8), pack8(tab[got].y));
                if (r8) got++;
            end
            if (v8 && rdy8) sent++;
        end
        v8 = 1'b0;
        r8 = 1'b1;
        check("stall_delivered", 64'(got), 64'd5);
        check("stall_seen", 64'(stall_done), 64'd1);

        // Three vectors held in flight, then a one-cycle reset flush.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            r8 = 1'b0;
            v8 = 1'b1;
            drive8(k);
        end
        @(negedge clk);
        drive8(3);
        rst = 1'b1;
        check("flush_pre_vo", 64'(vo8), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        v8  = 1'b0;
        check("flush_vo", 64'(vo8), 64'd0);
        check("flush_y", pack8(y8), 64'd0);
        check("flush_rdy", 64'(rdy8), 64'd1);
        r8   = 1'b1;
        leak = 0;
        repeat (10) begin
            @(negedge clk);
            if (vo8) leak++;
        end
        check("flush_no_leak", 64'(leak), 64'd0);
        run8(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the sequence above stalls on a broken design.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bitonic_merger_pipe.md
BITONIC_MERGER_PIPE -- requirements
Module: bitonic_merger_pipe

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, element width in bits (>=2).
REQ-002 SHALL have parameter DATALENGTH, default 16, element count; power of two, >=2; elaboration error otherwise.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  input vector valid.
REQ-006 SHALL have port ready_o  output  1  block accepts input this cycle.
REQ-007 SHALL have port sign_ctrl_i  input  1  1 = compare as two's-complement, 0 = unsigned; sampled with the vector.
REQ-008 SHALL have port dir_i  input  1  0 = ascending, 1 = descending; sampled with the vector.
REQ-009 SHALL have port x_i  input  DATAWIDTH x DATALENGTH  unpacked array holding a bitonic sequence; index 0 is the first element.
REQ-010 SHALL have port valid_o  output  1  result valid.
REQ-011 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-012 SHALL have port y_o  output  DATAWIDTH x DATALENGTH  merged, sorted sequence.

Function
REQ-013 SHALL implement S = log2(DATALENGTH) compare-and-swap stages; stage s (0..S-1) pairs index i with i+D, D = DATALENGTH>>(s+1), for every i whose bit log2(D) is 0.
REQ-014 Each pair SHALL place min at the lower index when ascending, or max when descending; equal values SHALL pass unswapped.
REQ-015 The comparison SHALL be signed or unsigned per that vector's captured sign_ctrl_i; mode and direction SHALL travel down the pipeline with the data, so mixed-mode back-to-back vectors are legal.
REQ-016 Every stage SHALL be registered; latency from accepted input to valid_o SHALL be exactly S cycles when not stalled.
REQ-017 A transfer SHALL occur on a cycle with valid_i && ready_o (input) or valid_o && ready_i (output).
REQ-018 ready_o SHALL equal !valid_o || ready_i; all stages SHALL advance together when ready_o = 1 and hold all data, valid, mode and direction when ready_o = 0.
REQ-019 Sustained throughput SHALL be one vector per cycle while ready_i = 1.
REQ-020 Holding empty stages SHALL NOT lose data; a bubble (valid bit 0) SHALL propagate as a bubble.
REQ-021 y_o and valid_o SHALL remain stable while valid_o && !ready_i.
REQ-022 Behaviour for a non-bitonic x_i is unspecified, but SHALL still be a permutation of x_i.

Reset
REQ-023 While rst_i = 1, all stage valid bits SHALL clear on the next edge; valid_o = 0, y_o = all zero, ready_o = 1 after that edge.
REQ-024 Reset mid-operation SHALL discard all in-flight vectors; no result of a pre-reset input SHALL ever appear.
REQ-025 An input offered in the cycle rst_i = 1 SHALL be ignored.

Structure
REQ-026 A shared package bitonic_pkg SHALL hold the direction enum (ASCEND = 0, DESCEND = 1) and a function returning log2 stage count.
REQ-027 One sub-module bitonic_merge_stage (parameters DATAWIDTH, DATALENGTH, STAGE) SHALL implement one combinational compare layer plus its register, valid, mode and direction bits, and enable; the top SHALL generate S instances.

Verification
REQ-028 DATALENGTH=8, unsigned, ascending, x=[1,3,5,7,8,6,4,2], ready_i=1 -> valid_o exactly 3 cycles later, y=[1,2,3,4,5,6,7,8].
REQ-029 Same vector with dir_i=1 -> y=[8,7,6,5,4,3,2,1].
REQ-030 DATALENGTH=4, x=[0x01,0x7F,0xFF,0x80], ascending; sign_ctrl=1 -> [0x80,0xFF,0x01,0x7F]; next cycle sign_ctrl=0 -> [0x01,0x7F,0x80,0xFF]; results on consecutive cycles.
REQ-031 DATALENGTH=8, five back-to-back vectors, ready_i low 4 cycles from first valid_o -> ready_o low, y_o stable, all five delivered in order once ready_i rises.
REQ-032 Three vectors in flight, rst_i pulsed one cycle -> valid_o = 0 and y_o = 0 after the edge; none of the three appear afterwards.
REQ-033 Inputs containing duplicates, e.g. x=[2,2,5,5,4,4,1,1] -> [1,1,2,2,4,4,5,5].
